// File: rtl/eval_sched_pkg.sv
// Shared types and width helpers for the evaluation phase sequencer.
// Optional one-deep pending trigger buffer: EVAL_SCHED_PENDING_EN.
package eval_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    EVAL  = 2'd2,
    OUT   = 2'd3
  } sched_state_t;

  localparam int DROP_W = 8;

  function automatic int lidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tmr_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/eval_scheduler_period_timer.sv
// Free-running deadline time base; ticks on the last count of each period.
// Frozen while en is low so deadlines shift with stalls.
module period_timer
  import eval_sched_pkg::*;
#(
  parameter int PERIOD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int TW = tmr_w(PERIOD_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(PERIOD_CYCLES - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + TW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/eval_scheduler.sv
// Phase sequencer: latch, one cycle per layer, then output phase.
// EVAL_SCHED_PENDING_EN buffers busy triggers; otherwise they are dropped.
module eval_scheduler
  import eval_sched_pkg::*;
#(
  parameter int NUM_INPUTS    = 1,
  parameter int NUM_LAYERS    = 3,
  parameter int PERIOD_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_INPUTS-1:0] newIn,
  output logic                  latchIn,
  output logic [NUM_INPUTS-1:0] evMask,
  output logic                  timedEval,
  output logic [NUM_LAYERS-1:0] layerEn,
  output logic                  outputPhase,
  output logic                  busy,
  output logic                  overrun,
  output logic [DROP_W-1:0]     dropCount
);

  localparam int KW = lidx_w(NUM_LAYERS);
  localparam logic [KW-1:0] LAST_K = KW'(NUM_LAYERS - 1);

  sched_state_t state, state_n;
  logic [KW-1:0] k, k_n;
  logic [NUM_INPUTS-1:0] mask_q, mask_n;
  logic timed_q, timed_n;
  logic ovr_q, ovr_n;
  logic [DROP_W-1:0] drop_q, drop_n;
  logic tick, trig;

`ifdef EVAL_SCHED_PENDING_EN
  logic pend_v, pv_n;
  logic [NUM_INPUTS-1:0] pend_m, pm_n;
  logic pend_t, pt_n;
`endif

  period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  assign trig = (|newIn) | tick;

  always_comb begin
    state_n = state;
    k_n     = k;
    mask_n  = mask_q;
    timed_n = timed_q;
    ovr_n   = 1'b0;
    drop_n  = drop_q;
`ifdef EVAL_SCHED_PENDING_EN
    pv_n = pend_v;
    pm_n = pend_m;
    pt_n = pend_t;
`endif
    if (en) begin
      unique case (state)
        IDLE: begin
          if (trig) begin
            state_n = LATCH;
            mask_n  = newIn;
            timed_n = tick;
          end
        end
        LATCH: begin
          state_n = EVAL;
          k_n     = '0;
        end
        EVAL: begin
          if (k == LAST_K) state_n = OUT;
          else             k_n = k + KW'(1);
        end
        OUT: begin
          state_n = IDLE;
          mask_n  = '0;
          timed_n = 1'b0;
`ifdef EVAL_SCHED_PENDING_EN
          if (pend_v) begin
            state_n = LATCH;
            mask_n  = pend_m;
            timed_n = pend_t;
            pv_n    = 1'b0;
            pm_n    = '0;
            pt_n    = 1'b0;
          end else if (trig) begin
            // empty buffer: start the next pass straight away
            state_n = LATCH;
            mask_n  = newIn;
            timed_n = tick;
          end
`endif
        end
        default: state_n = IDLE;
      endcase

      if (state != IDLE && trig) begin
`ifdef EVAL_SCHED_PENDING_EN
        if (state == OUT) begin
          if (pend_v) begin
            pv_n = 1'b1;
            pm_n = newIn;
            pt_n = tick;
          end
        end else begin
          ovr_n = pend_v;
          pv_n  = 1'b1;
          pm_n  = pend_m | newIn;
          pt_n  = pend_t | tick;
        end
`else
        ovr_n = 1'b1;
`endif
      end

      if (ovr_n && drop_q != {DROP_W{1'b1}})
        drop_n = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      k       <= '0;
      mask_q  <= '0;
      timed_q <= 1'b0;
      ovr_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state   <= state_n;
      k       <= k_n;
      mask_q  <= mask_n;
      timed_q <= timed_n;
      ovr_q   <= ovr_n;
      drop_q  <= drop_n;
    end
  end

`ifdef EVAL_SCHED_PENDING_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v <= 1'b0;
      pend_m <= '0;
      pend_t <= 1'b0;
    end else begin
      pend_v <= pv_n;
      pend_m <= pm_n;
      pend_t <= pt_n;
    end
  end
`endif

  always_comb begin
    layerEn = '0;
    if (en && state == EVAL) begin
      for (int i = 0; i < NUM_LAYERS; i++)
        layerEn[i] = (k == KW'(i));
    end
  end

  assign latchIn     = en && (state == LATCH);
  assign outputPhase = en && (state == OUT);
  assign overrun     = en && ovr_q;
  assign busy        = (state != IDLE);
  assign evMask      = mask_q;
  assign timedEval   = timed_q;
  assign dropCount   = drop_q;

endmodule

// File: tb/tb_eval_scheduler.sv
// Directed bench for eval_scheduler at default parameters.
// Cycle 0 begins at reset release; outputs sampled mid-cycle.
module tb_eval_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1;
  logic [0:0] newIn = 1'b0;
  logic latchIn, timedEval, outputPhase, busy, overrun;
  logic [0:0] evMask;
  logic [2:0] layerEn;
  logic [7:0] dropCount;

  int vecs = 0;
  int errs = 0;

  eval_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .newIn      (newIn),
    .latchIn    (latchIn),
    .evMask     (evMask),
    .timedEval  (timedEval),
    .layerEn    (layerEn),
    .outputPhase(outputPhase),
    .busy       (busy),
    .overrun    (overrun),
    .dropCount  (dropCount)
  );

  always #5 clk = ~clk;

  wire [8:0] obs = {latchIn, layerEn, outputPhase, busy,
                    evMask, timedEval, overrun};

  // Expected bundle for a pass whose LATCH cycle is s.
  function automatic logic [8:0] pv(int c, int s, logic m, logic t);
    int d;
    logic [2:0] le;
    d = c - s;
    if (d < 0 || d > 4) return 9'd0;
    le = (d == 1) ? 3'b001 : (d == 2) ? 3'b010 :
         (d == 3) ? 3'b100 : 3'b000;
    return {d == 0, le, d == 4, 1'b1, m, t, 1'b0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    newIn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    vecs++;
    if (obs !== 9'd0 || dropCount !== 8'd0) begin
      errs++;
      $display("FAIL reset_held: got %b/%0d want 0/0", obs, dropCount);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    vecs++;
    if (obs !== 9'd0 || dropCount !== 8'd0) begin
      errs++;
      $display("FAIL reset_release: got %b/%0d want 0/0", obs, dropCount);
    end
  endtask

  task automatic test_timer();
    logic [8:0] want;
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      #1;
      want = pv(c, 10, 1'b0, 1'b1);
      vecs++;
      if (obs !== want) begin
        errs++;
        $display("FAIL timer c%0d: got %b want %b", c, obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_event();
    logic [8:0] want;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      newIn = (c == 2);
      #1;
      want = pv(c, 3, 1'b1, 1'b0) | pv(c, 10, 1'b0, 1'b1);
      vecs++;
      if (obs !== want) begin
        errs++;
        $display("FAIL event c%0d: got %b want %b", c, obs, want);
      end
      @(negedge clk);
    end
    newIn = 1'b0;
  endtask

  task automatic test_coincident();
    logic [8:0] want;
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      newIn = (c == 9);
      #1;
      want = pv(c, 10, 1'b1, 1'b1);
      vecs++;
      if (obs !== want) begin
        errs++;
        $display("FAIL coincident c%0d: got %b want %b", c, obs, want);
      end
      @(negedge clk);
    end
    newIn = 1'b0;
  endtask

  task automatic test_busy_trigger();
    logic [8:0] want;
    int pulses;
    pulses = 0;
    do_reset();
`ifdef EVAL_SCHED_PENDING_EN
    for (int c = 0; c <= 14; c++) begin
      newIn = (c == 2 || c == 4);
      #1;
      want = pv(c, 3, 1'b1, 1'b0) | pv(c, 8, 1'b1, 1'b0) |
             pv(c, 13, 1'b0, 1'b1);
      vecs++;
      if (obs !== want) begin
        errs++;
        $display("FAIL pending c%0d: got %b want %b", c, obs, want);
      end
      @(negedge clk);
    end
    #1;
    vecs++;
    if (dropCount !== 8'd0) begin
      errs++;
      $display("FAIL pending_drops: got %0d want 0", dropCount);
    end
`else
    for (int c = 0; c <= 11; c++) begin
      newIn = (c == 2 || c == 4);
      #1;
      want = pv(c, 3, 1'b1, 1'b0) | pv(c, 10, 1'b0, 1'b1);
      if (overrun === 1'b1) pulses++;
      vecs++;
      if (obs[8:1] !== want[8:1]) begin
        errs++;
        $display("FAIL drop c%0d: got %b want %b", c, obs, want);
      end
      @(negedge clk);
    end
    #1;
    vecs++;
    if (pulses != 1 || dropCount !== 8'd1) begin
      errs++;
      $display("FAIL drop_count: got %0d pulses/%0d want 1/1",
               pulses, dropCount);
    end
`endif
    newIn = 1'b0;
  endtask

  task automatic test_enable();
    logic [8:0] want;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      newIn = (c == 2);
      en = !(c >= 5 && c <= 7);
      #1;
      if (c < 5)       want = pv(c, 3, 1'b1, 1'b0);
      else if (c <= 7) want = 9'b0_000_0_1_1_0_0;
      else             want = pv(c, 6, 1'b1, 1'b0) | pv(c, 13, 1'b0, 1'b1);
      vecs++;
      if (obs !== want) begin
        errs++;
        $display("FAIL enable c%0d: got %b want %b", c, obs, want);
      end
      @(negedge clk);
    end
    en = 1'b1;
    newIn = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [8:0] want;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      newIn = (c == 2);
      @(negedge clk);
    end
    newIn = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    vecs++;
    if (obs !== 9'd0) begin
      errs++;
      $display("FAIL reset_mid: got %b want 0", obs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      #1;
      want = pv(c, 10, 1'b0, 1'b1);
      vecs++;
      if (obs !== want) begin
        errs++;
        $display("FAIL after_reset c%0d: got %b want %b", c, obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    newIn = 1'b1;
    repeat (700) @(negedge clk);
    newIn = 1'b0;
    #1;
    vecs++;
    if (dropCount !== 8'd255) begin
      errs++;
      $display("FAIL saturate: got %0d want 255", dropCount);
    end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_event();
    test_coincident();
    test_busy_trigger();
    test_enable();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
